instruction_fetch_unit: RTL and testbench

Front end of the pipeline. Holds the program counter, drives the word address into the instruction memory, and captures the returned instruction with its PC into an IF/ID output register under a valid/ready handshake. Supports stall, branch/jump redirect with flush, and a halt-on-fault state for misaligned or out-of-range PCs. Sits directly upstream of the instruction memory and downstream of the decode stage's redirect/stall outputs.

---
 rtl/instruction_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Pipeline front end. Holds the program counter, presents the word address to
// a combinational instruction memory, and captures the returned instruction
// with its PC into an IF/ID register under a valid/ready handshake. Supports
// stall, branch/jump redirect with flush, and a sticky halt-on-fault state for
// misaligned or out-of-range PCs.
//
// Parameters
//   RESET_PC    byte address loaded into the PC on reset
//   IMEM_DEPTH  number of 32-bit words in instruction memory
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-high reset
//   stall            hold PC and IF/ID contents (decode hazard)
//   redirect_valid   taken branch/jump this cycle
//   redirect_target  byte address of the next instruction
//   imem_addr        word index into instruction memory ({2'b00, pc[63:2]})
//   imem_instr       instruction returned combinationally for imem_addr
//   ifid_valid       IF/ID register holds a valid instruction
//   ifid_pc          byte PC of the held instruction
//   ifid_instr       held instruction
//   ifid_ready       decode accepts IF/ID contents this cycle
//   fetch_fault      sticky misaligned / out-of-range PC indication
//   fetch_count      instructions accepted by decode (wraps at 2^32)
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  input  logic        ifid_ready,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // A PC is unusable when it is not word aligned or its word index lies past
  // the end of instruction memory. A wrapped pc+4 lands at a small value only
  // after passing through huge addresses, which this check has already caught.
  function automatic logic pc_bad(input logic [63:0] addr);
    pc_bad = (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(IMEM_DEPTH));
  endfunction

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic        accept;
  logic        adv;
  logic [63:0] pc_plus4;

  assign accept   = ifid_valid_q && ifid_ready;
  assign adv      = !stall && (!ifid_valid_q || ifid_ready);
  assign pc_plus4 = pc_q + 64'd4;

  assign imem_addr   = {2'b00, pc_q[63:2]};
  assign ifid_valid  = ifid_valid_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    fault_d      = fault_q;
    count_d      = count_q;

    // A handshake completes whatever else happens this cycle, including
    // during a stall or a flushing redirect.
    if (accept) begin
      count_d = count_q + 32'd1;
    end

    unique case (state_q)
      BOOT: begin
        if (pc_bad(RESET_PC)) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (redirect_valid) begin
          // Flush: the instruction at the old PC is discarded.
          pc_d         = redirect_target;
          ifid_valid_d = 1'b0;
          if (pc_bad(redirect_target)) begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end else if (adv) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = imem_instr;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          // The entry fetched this cycle is still delivered; only the next
          // fetch is blocked.
          if (pc_bad(pc_plus4)) begin
            fault_d = 1'b1;
            state_d = HALT;
          end
        end else if (accept) begin
          ifid_valid_d = 1'b0;
        end
      end

      HALT: begin
        if (accept) begin
          ifid_valid_d = 1'b0;
        end
        // Only a usable target restarts fetching; faulty targets are ignored.
        if (redirect_valid && !pc_bad(redirect_target)) begin
          pc_d         = redirect_target;
          ifid_valid_d = 1'b0;
          fault_d      = 1'b0;
          state_d      = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 64'd0;
      ifid_instr_q <= 32'd0;
      fault_q      <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      fault_q      <= fault_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. A transaction-level model of the
// fetch front end is advanced once per clock edge by the stimulus thread; a
// compare process checks every DUT output against it on each falling edge,
// and hand-computed literal expectations pin both along the directed sequence.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_ready;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int total;
  int bad;
  bit running;

  // Model state
  logic [63:0] m_pc;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic [31:0] m_count;
  bit          m_valid;
  bit          m_fault;
  bit          m_boot;
  bit          m_halt;

  instruction_fetch_unit #(
    .RESET_PC  (64'h0),
    .IMEM_DEPTH(32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_ready     (ifid_ready),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  // Program image: word i holds 0x1000_0000 + i; outside memory reads garbage.
  function automatic logic [31:0] mem_word(input logic [63:0] widx);
    if (widx < 64'd32) return 32'h1000_0000 + widx[31:0];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit bad_pc(input logic [63:0] a);
    return (a % 64'd4 != 64'd0) || (a / 64'd4 >= 64'd32);
  endfunction

  task automatic model_reset();
    m_pc    = 64'h0;
    m_ipc   = 64'h0;
    m_instr = 32'h0;
    m_count = 32'h0;
    m_valid = 1'b0;
    m_fault = 1'b0;
    m_boot  = 1'b1;
    m_halt  = 1'b0;
  endtask

  // One clock edge of the front end, from its behavioural rules.
  task automatic model_edge();
    bit acc;
    acc = m_valid && ifid_ready;
    if (acc) m_count = m_count + 32'd1;
    if (m_boot) begin
      m_boot = 1'b0;
      if (bad_pc(64'h0)) begin
        m_halt  = 1'b1;
        m_fault = 1'b1;
      end
    end else if (m_halt) begin
      if (acc) m_valid = 1'b0;
      if (redirect_valid && !bad_pc(redirect_target)) begin
        m_pc    = redirect_target;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_halt  = 1'b0;
      end
    end else if (redirect_valid) begin
      m_pc    = redirect_target;
      m_valid = 1'b0;
      if (bad_pc(m_pc)) begin
        m_halt  = 1'b1;
        m_fault = 1'b1;
      end
    end else if (!stall && (!m_valid || ifid_ready)) begin
      m_ipc   = m_pc;
      m_instr = mem_word(m_pc / 64'd4);
      m_valid = 1'b1;
      m_pc    = m_pc + 64'd4;
      if (bad_pc(m_pc)) begin
        m_halt  = 1'b1;
        m_fault = 1'b1;
      end
    end else if (acc) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Literal expectation for one observation point.
  task automatic expect_out(input string tag, input bit v, input logic [63:0] pc,
                            input logic [31:0] ins, input bit f,
                            input logic [31:0] cnt, input logic [63:0] addr);
    chk({tag, ".valid"}, {63'd0, ifid_valid}, {63'd0, v});
    if (v) begin
      chk({tag, ".pc"}, ifid_pc, pc);
      chk({tag, ".instr"}, {32'd0, ifid_instr}, {32'd0, ins});
    end
    chk({tag, ".fault"}, {63'd0, fetch_fault}, {63'd0, f});
    chk({tag, ".count"}, {32'd0, fetch_count}, {32'd0, cnt});
    chk({tag, ".addr"}, imem_addr, addr);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (running) begin
      chk("cmp.valid", {63'd0, ifid_valid}, {63'd0, m_valid});
      chk("cmp.pc", ifid_pc, m_ipc);
      chk("cmp.instr", {32'd0, ifid_instr}, {32'd0, m_instr});
      chk("cmp.fault", {63'd0, fetch_fault}, {63'd0, m_fault});
      chk("cmp.count", {32'd0, fetch_count}, {32'd0, m_count});
      chk("cmp.addr", imem_addr, m_pc / 64'd4);
    end
  end

  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 64'h0;
    ifid_ready = 1'b1;
    model_reset();
    running = 1'b1;

    @(negedge clk);
    chk("rst.pc", ifid_pc, 64'h0);
    chk("rst.instr", {32'd0, ifid_instr}, 64'h0);
    expect_out("rst", 0, 64'h0, 32'h0, 0, 32'd0, 64'h0);
    reset = 1'b0;

    // Boot bubble, then sequential fetch with decode always ready.
    step(); expect_out("boot", 0, 64'h0, 32'h0, 0, 32'd0, 64'h0);
    step(); expect_out("seq0", 1, 64'h0, 32'h1000_0000, 0, 32'd0, 64'h1);
    step(); expect_out("seq4", 1, 64'h4, 32'h1000_0001, 0, 32'd1, 64'h2);
    step(); expect_out("seq8", 1, 64'h8, 32'h1000_0002, 0, 32'd2, 64'h3);

    // Decode back-pressure holds the entry at pc=8.
    ifid_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("hold8", 1, 64'h8, 32'h1000_0002, 0, 32'd2, 64'h3);
    end
    ifid_ready = 1'b1;
    step(); expect_out("rel12", 1, 64'hC, 32'h1000_0003, 0, 32'd3, 64'h4);
    step(); expect_out("seq16", 1, 64'h10, 32'h1000_0004, 0, 32'd4, 64'h5);

    // Redirect wins over stall and flushes the held entry.
    stall = 1'b1; ifid_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 64'h40;
    step(); expect_out("redir40", 0, 64'h0, 32'h0, 0, 32'd4, 64'h10);
    stall = 1'b0; ifid_ready = 1'b1; redirect_valid = 1'b0;
    step(); expect_out("fetch40", 1, 64'h40, 32'h1000_0010, 0, 32'd4, 64'h11);

    // Misaligned redirect: entry still accepted, then halt with fault.
    redirect_valid = 1'b1; redirect_target = 64'h42;
    step(); expect_out("mis42", 0, 64'h0, 32'h0, 1, 32'd5, 64'h10);
    redirect_valid = 1'b0;
    step(); expect_out("halt1", 0, 64'h0, 32'h0, 1, 32'd5, 64'h10);
    step(); expect_out("halt2", 0, 64'h0, 32'h0, 1, 32'd5, 64'h10);

    // Good redirect leaves halt; first fetch one cycle later.
    redirect_valid = 1'b1; redirect_target = 64'h10;
    step(); expect_out("resume", 0, 64'h0, 32'h0, 0, 32'd5, 64'h4);
    redirect_valid = 1'b0;
    step(); expect_out("fetch10", 1, 64'h10, 32'h1000_0004, 0, 32'd5, 64'h5);

    // Stall with decode ready: entry accepted, bubble, PC held.
    stall = 1'b1;
    step(); expect_out("stallbub", 0, 64'h0, 32'h0, 0, 32'd6, 64'h5);
    stall = 1'b0;
    step(); expect_out("fetch14", 1, 64'h14, 32'h1000_0005, 0, 32'd6, 64'h6);

    // Run off the end of memory.
    redirect_valid = 1'b1; redirect_target = 64'h70;
    step(); expect_out("redir70", 0, 64'h0, 32'h0, 0, 32'd7, 64'h1C);
    redirect_valid = 1'b0;
    step(); expect_out("fetch70", 1, 64'h70, 32'h1000_001C, 0, 32'd7, 64'h1D);
    step(); expect_out("fetch74", 1, 64'h74, 32'h1000_001D, 0, 32'd8, 64'h1E);
    step(); expect_out("fetch78", 1, 64'h78, 32'h1000_001E, 0, 32'd9, 64'h1F);
    step(); expect_out("fetch7C", 1, 64'h7C, 32'h1000_001F, 1, 32'd10, 64'h20);
    step(); expect_out("drain", 0, 64'h0, 32'h0, 1, 32'd11, 64'h20);
    step(); expect_out("halted", 0, 64'h0, 32'h0, 1, 32'd11, 64'h20);

    redirect_valid = 1'b1; redirect_target = 64'h0;
    step(); expect_out("resume0", 0, 64'h0, 32'h0, 0, 32'd11, 64'h0);
    redirect_valid = 1'b0;
    step(); expect_out("again0", 1, 64'h0, 32'h1000_0000, 0, 32'd11, 64'h1);
    step(); expect_out("again4", 1, 64'h4, 32'h1000_0001, 0, 32'd12, 64'h2);

    // Asynchronous reset mid-run clears everything immediately.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst.pc", ifid_pc, 64'h0);
    chk("midrst.instr", {32'd0, ifid_instr}, 64'h0);
    expect_out("midrst", 0, 64'h0, 32'h0, 0, 32'd0, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    step(); expect_out("reboot", 0, 64'h0, 32'h0, 0, 32'd0, 64'h0);
    step(); expect_out("refetch0", 1, 64'h0, 32'h1000_0000, 0, 32'd0, 64'h1);

    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
